// File: rtl/adder_stim_gen.sv
// Operand stimulus generator for an adder under test: directed table, exhaustive sweep or LFSR random runs.
// First operands appear the cycle after start; operands advance once per valid/ready transfer and hold while stalled.
module adder_stim_gen #(
  parameter int  WIDTH     = 4,
  parameter int  TBL_DEPTH = 8,
  parameter int  NUM_RAND  = 16,
  localparam int AW        = $clog2(TBL_DEPTH),
  localparam int CW        = 2*WIDTH+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [31:0]      seed,
  input  logic             tbl_wr_en,
  input  logic [AW-1:0]    tbl_wr_addr,
  input  logic [WIDTH-1:0] tbl_wr_a,
  input  logic [WIDTH-1:0] tbl_wr_b,
  input  logic [AW:0]      tbl_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    txn_count
);

  // Internal counters are wide enough for both the sweep length and NUM_RAND.
  localparam int LW = (CW > 16) ? CW : 16;

  localparam logic [31:0]   LFSR_MASK = 32'h8020_0003;
  localparam logic [AW:0]   DEPTH_LEN = (AW+1)'(TBL_DEPTH);
  localparam logic [LW-1:0] SWEEP_LEN = LW'(1) << (2*WIDTH);
  localparam logic [LW-1:0] RAND_LEN  = LW'(NUM_RAND);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [31:0]        lfsr_q, lfsr_d;

  logic [WIDTH-1:0]   tbl_a_mem [TBL_DEPTH];
  logic [WIDTH-1:0]   tbl_b_mem [TBL_DEPTH];

  logic [31:0]        lfsr_first, lfsr_nxt;
  logic [AW:0]        clamp_len;
  logic [WIDTH-1:0]   first_a, first_b;
  logic [AW-1:0]      next_idx;
  logic [2*WIDTH-1:0] sweep_nxt;
  logic               xfer, last;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  always_comb begin
    lfsr_first = lfsr_step((seed == 32'd0) ? 32'd1 : seed);
    lfsr_nxt   = lfsr_step(lfsr_q);
    clamp_len  = (tbl_len > DEPTH_LEN) ? DEPTH_LEN : tbl_len;
    // A write to entry 0 in the start cycle must be seen by this run.
    first_a    = (tbl_wr_en && tbl_wr_addr == '0) ? tbl_wr_a : tbl_a_mem[0];
    first_b    = (tbl_wr_en && tbl_wr_addr == '0) ? tbl_wr_b : tbl_b_mem[0];
    next_idx   = cnt_q[AW-1:0] + AW'(1);
    sweep_nxt  = {b_q, a_q} + (2*WIDTH)'(1);
    xfer       = (state_q == S_RUN) && out_ready;
    last       = (cnt_q + LW'(1)) == len_q;

    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    lfsr_d  = lfsr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d = mode;
          cnt_d  = '0;
          lfsr_d = lfsr_first;
          case (mode)
            2'd0: begin
              len_d   = LW'(clamp_len);
              a_d     = first_a;
              b_d     = first_b;
              state_d = (clamp_len == '0) ? S_DONE : S_RUN;
            end
            2'd1: begin
              len_d   = SWEEP_LEN;
              a_d     = '0;
              b_d     = '0;
              state_d = S_RUN;
            end
            2'd2: begin
              len_d   = RAND_LEN;
              a_d     = lfsr_first[WIDTH-1:0];
              b_d     = lfsr_first[2*WIDTH-1:WIDTH];
              state_d = S_RUN;
            end
            default: begin
              len_d   = '0;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_RUN: begin
        if (xfer) begin
          cnt_d = cnt_q + LW'(1);
          if (last) begin
            state_d = S_DONE;
          end else begin
            case (mode_q)
              2'd0: begin
                a_d = tbl_a_mem[next_idx];
                b_d = tbl_b_mem[next_idx];
              end
              2'd1: {b_d, a_d} = sweep_nxt;
              default: begin
                lfsr_d = lfsr_nxt;
                a_d    = lfsr_nxt[WIDTH-1:0];
                b_d    = lfsr_nxt[2*WIDTH-1:WIDTH];
              end
            endcase
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      len_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lfsr_q  <= 32'd1;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Table contents survive reset; the table is frozen while a run is in flight.
  always_ff @(posedge clk) begin
    if (tbl_wr_en && (state_q != S_RUN)) begin
      tbl_a_mem[tbl_wr_addr] <= tbl_wr_a;
      tbl_b_mem[tbl_wr_addr] <= tbl_wr_b;
    end
  end

  assign out_valid = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign a         = a_q;
  assign b         = b_q;
  assign txn_count = cnt_q[CW-1:0];

endmodule

// File: tb/tb_adder_stim_gen.sv
// Self-checking bench for adder_stim_gen: vector table of runs, reference model, reset and sweep sequences.
module tb_adder_stim_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, tbl_wr_en, out_ready;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic [2:0]  tbl_wr_addr;
  logic [3:0]  tbl_wr_a, tbl_wr_b, tbl_len;
  logic        out_valid, busy, done;
  logic [3:0]  a, b;
  logic [8:0]  txn_count;

  logic        start2, tbl_wr_en2, out_ready2;
  logic [1:0]  mode2;
  logic [31:0] seed2;
  logic [2:0]  tbl_wr_addr2;
  logic [1:0]  tbl_wr_a2, tbl_wr_b2;
  logic [3:0]  tbl_len2;
  logic        out_valid2, busy2, done2;
  logic [1:0]  a2, b2;
  logic [4:0]  txn_count2;

  adder_stim_gen #(.WIDTH(4), .TBL_DEPTH(8), .NUM_RAND(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_a(tbl_wr_a), .tbl_wr_b(tbl_wr_b),
    .tbl_len(tbl_len), .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b),
    .busy(busy), .done(done), .txn_count(txn_count)
  );

  adder_stim_gen #(.WIDTH(2), .TBL_DEPTH(8), .NUM_RAND(16)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2), .seed(seed2),
    .tbl_wr_en(tbl_wr_en2), .tbl_wr_addr(tbl_wr_addr2), .tbl_wr_a(tbl_wr_a2), .tbl_wr_b(tbl_wr_b2),
    .tbl_len(tbl_len2), .out_valid(out_valid2), .out_ready(out_ready2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .txn_count(txn_count2)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] seed;
    logic [3:0]  len;
    int          stall;      // 0 always ready, 1 stall 3 cycles first, 2 random
    bit          noise;      // pulse start / table writes while running
    int          exp_n;
    bit          chk_first;
    logic [3:0]  fa, fb;
    bit          wr0;        // write entry 0 = (7,9) in the start cycle
  } vec_t;

  vec_t vecs[11];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] m_a[8], m_b[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic write_tbl(input int addr, input logic [3:0] wa, input logic [3:0] wb);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = 3'(addr);
    tbl_wr_a    = wa;
    tbl_wr_b    = wb;
    @(negedge clk);
    tbl_wr_en = 1'b0;
    m_a[addr] = wa;
    m_b[addr] = wb;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic [3:0]  ea[$];
    logic [3:0]  eb[$];
    logic [31:0] s;
    int          n, k;
    bit          rdy, fin;
    if (v.wr0) begin
      m_a[0] = 4'd7;
      m_b[0] = 4'd9;
    end
    case (v.mode)
      2'd0: begin
        n = (int'(v.len) > 8) ? 8 : int'(v.len);
        for (int i = 0; i < n; i++) begin ea.push_back(m_a[i]); eb.push_back(m_b[i]); end
      end
      2'd1: begin
        n = 256;
        for (int i = 0; i < n; i++) begin ea.push_back(4'(i % 16)); eb.push_back(4'(i / 16)); end
      end
      2'd2: begin
        n = 16;
        s = (v.seed == 32'd0) ? 32'd1 : v.seed;
        for (int i = 0; i < n; i++) begin
          s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
          ea.push_back(s[3:0]);
          eb.push_back(s[7:4]);
        end
      end
      default: n = 0;
    endcase

    start = 1'b1; mode = v.mode; seed = v.seed; tbl_len = v.len; out_ready = 1'b0;
    if (v.wr0) begin
      tbl_wr_en = 1'b1; tbl_wr_addr = 3'd0; tbl_wr_a = 4'd7; tbl_wr_b = 4'd9;
    end
    @(negedge clk);
    start = 1'b0; tbl_wr_en = 1'b0;
    mode = 2'($urandom); seed = $urandom; tbl_len = 4'($urandom);
    k = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (k < n) begin
        if (!out_valid) begin
          $display("FAIL v%0d valid_gap: got out_valid=0 expected 1 at transfer %0d", id, k);
          checks++; errors++;
          fin = 1'b1;
        end else begin
          if (k == 0 && v.chk_first) begin
            chk($sformatf("v%0d first_a", id), 64'(a), 64'(v.fa));
            chk($sformatf("v%0d first_b", id), 64'(b), 64'(v.fb));
          end
          chk($sformatf("v%0d a[%0d]", id, k), 64'(a), 64'(ea[k]));
          chk($sformatf("v%0d b[%0d]", id, k), 64'(b), 64'(eb[k]));
          chk($sformatf("v%0d cnt_run", id), 64'(txn_count), 64'(k));
          case (v.stall)
            0:       rdy = 1'b1;
            1:       rdy = (cyc >= 3);
            default: rdy = 1'($urandom);
          endcase
          out_ready = rdy;
          if (v.noise) begin
            start = ($urandom % 4 == 0); mode = 2'($urandom);
            tbl_wr_en = 1'($urandom); tbl_wr_addr = 3'($urandom);
            tbl_wr_a = 4'($urandom); tbl_wr_b = 4'($urandom);
          end
          if (rdy) k++;
          @(negedge clk);
        end
      end else begin
        start = 1'b0; tbl_wr_en = 1'b0;
        chk($sformatf("v%0d done", id), 64'(done), 64'd1);
        chk($sformatf("v%0d valid_off", id), 64'(out_valid), 64'd0);
        chk($sformatf("v%0d busy_off", id), 64'(busy), 64'd0);
        chk($sformatf("v%0d txn_count", id), 64'(txn_count), 64'(v.exp_n));
        if (n > 0) begin
          chk($sformatf("v%0d hold_a", id), 64'(a), 64'(ea[n-1]));
          chk($sformatf("v%0d hold_b", id), 64'(b), 64'(eb[n-1]));
        end
        out_ready = 1'($urandom);
        @(negedge clk);
        chk($sformatf("v%0d done_stay", id), 64'(done), 64'd1);
        chk($sformatf("v%0d cnt_stay", id), 64'(txn_count), 64'(v.exp_n));
        fin = 1'b1;
      end
    end
    start = 1'b0; tbl_wr_en = 1'b0;
    if (!fin) chk($sformatf("v%0d timeout", id), 64'd0, 64'd1);
  endtask

  initial begin
    vec_t vr;
    //          mode   seed       len    stall noise exp  chk  fa     fb     wr0
    vecs[0]  = '{2'd0, 32'd0,     4'd2,  0,    1'b0, 2,   1'b1, 4'd10, 4'd5, 1'b0};
    vecs[1]  = '{2'd0, 32'd0,     4'd2,  1,    1'b0, 2,   1'b1, 4'd10, 4'd5, 1'b0};
    vecs[2]  = '{2'd2, 32'd0,     4'd0,  0,    1'b0, 16,  1'b1, 4'd3,  4'd0, 1'b0};
    vecs[3]  = '{2'd2, 32'd1,     4'd0,  0,    1'b0, 16,  1'b1, 4'd3,  4'd0, 1'b0};
    vecs[4]  = '{2'd3, 32'd5,     4'd3,  0,    1'b0, 0,   1'b0, 4'd0,  4'd0, 1'b0};
    vecs[5]  = '{2'd0, 32'd0,     4'd0,  0,    1'b0, 0,   1'b0, 4'd0,  4'd0, 1'b0};
    vecs[6]  = '{2'd0, 32'd0,     4'd12, 2,    1'b1, 8,   1'b1, 4'd10, 4'd5, 1'b0};
    vecs[7]  = '{2'd1, 32'd0,     4'd0,  2,    1'b1, 256, 1'b1, 4'd0,  4'd0, 1'b0};
    vecs[8]  = '{2'd2, $urandom,  4'd0,  2,    1'b1, 16,  1'b0, 4'd0,  4'd0, 1'b0};
    vecs[9]  = '{2'd2, 32'd1,     4'd0,  2,    1'b0, 16,  1'b1, 4'd3,  4'd0, 1'b0};
    vecs[10] = '{2'd0, 32'd0,     4'd1,  0,    1'b0, 1,   1'b1, 4'd7,  4'd9, 1'b1};

    rst = 1'b1; start = 1'b1; mode = 2'd1; seed = 32'd0; tbl_wr_en = 1'b0; tbl_wr_addr = 3'd0;
    tbl_wr_a = 4'd0; tbl_wr_b = 4'd0; tbl_len = 4'd0; out_ready = 1'b0;
    start2 = 1'b0; mode2 = 2'd1; seed2 = 32'd0; tbl_wr_en2 = 1'b0; tbl_wr_addr2 = 3'd0;
    tbl_wr_a2 = 2'd0; tbl_wr_b2 = 2'd0; tbl_len2 = 4'd0; out_ready2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst a", 64'(a), 64'd0);
    chk("rst b", 64'(b), 64'd0);
    chk("rst txn_count", 64'(txn_count), 64'd0);
    rst = 1'b0; start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("idle ready no effect valid", 64'(out_valid), 64'd0);
    chk("idle ready no effect cnt", 64'(txn_count), 64'd0);

    write_tbl(0, 4'd10, 4'd5);
    write_tbl(1, 4'd6, 4'd4);
    for (int i = 2; i < 8; i++) write_tbl(i, 4'($urandom), 4'($urandom));

    // Exhaustive sweep on the 2-bit instance.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("sweep2 valid[%0d]", i), 64'(out_valid2), 64'd1);
      chk($sformatf("sweep2 ba[%0d]", i), 64'({b2, a2}), 64'(i));
      @(negedge clk);
    end
    chk("sweep2 done", 64'(done2), 64'd1);
    chk("sweep2 valid_off", 64'(out_valid2), 64'd0);
    chk("sweep2 txn_count", 64'(txn_count2), 64'd16);
    chk("sweep2 hold", 64'({b2, a2}), 64'd15);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a sweep, with a coincident start.
    start = 1'b1; mode = 2'd1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mid a[%0d]", i), 64'(a), 64'(i));
      @(negedge clk);
    end
    chk("mid txn_count", 64'(txn_count), 64'd5);
    rst = 1'b1; start = 1'b1; mode = 2'd1; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst a", 64'(a), 64'd0);
    chk("midrst b", 64'(b), 64'd0);
    chk("midrst txn_count", 64'(txn_count), 64'd0);
    @(negedge clk);
    chk("rst start ignored", 64'(busy), 64'd0);
    vr = vecs[7];
    vr.stall = 0;
    vr.noise = 1'b0;
    run_vec(11, vr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_stim_gen.md
ADDER_STIM_GEN -- requirements
Module: adder_stim_gen

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 1..16.
REQ-002 Parameter TBL_DEPTH, default 8, number of directed-table entries; power of two, 2..256.
REQ-003 Parameter NUM_RAND, default 16, number of random transactions per run; range 1..65535.
REQ-004 Localparam AW = log2(TBL_DEPTH); localparam CW = 2*WIDTH+1.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle run request; sampled only in IDLE or DONE.
REQ-008 mode  in  2  0 directed, 1 exhaustive sweep, 2 LFSR random, 3 reserved; sampled with start.
REQ-009 seed  in  32  LFSR seed; sampled with start.
REQ-010 tbl_wr_en  in  1  directed-table write strobe.
REQ-011 tbl_wr_addr  in  AW  table write address.
REQ-012 tbl_wr_a, tbl_wr_b  in  WIDTH each  table entry operands.
REQ-013 tbl_len  in  AW+1  number of table entries to issue; sampled with start.
REQ-014 out_valid  out  1  a/b hold a valid transaction.
REQ-015 out_ready  in  1  consumer accepts transaction this cycle.
REQ-016 a, b  out  WIDTH each  operand values to the adder under test.
REQ-017 busy  out  1  high in RUN state.
REQ-018 done  out  1  high in DONE state.
REQ-019 txn_count  out  CW  transfers completed in current/last run.

Function
REQ-020 FSM states IDLE, RUN, DONE; a transfer occurs on any cycle with out_valid and out_ready both high.
REQ-021 IDLE/DONE + start: latch mode, seed, tbl_len; clear txn_count; next cycle RUN, out_valid=1 with first operands; start=0 holds state.
REQ-022 RUN: out_valid stays 1; a, b, out_valid SHALL NOT change while out_valid=1 and out_ready=0.
REQ-023 On each transfer: txn_count+1; next operands presented the following cycle without a bubble, unless the transfer was the last.
REQ-024 Run length: mode 0 = latched tbl_len (clamped to TBL_DEPTH); mode 1 = 2^(2*WIDTH); mode 2 = NUM_RAND.
REQ-025 After the last transfer: next cycle DONE, out_valid=0, done=1; a, b hold last values; txn_count holds final count.
REQ-026 Mode 0: entry i issued as transfer i, i = 0..len-1, in address order.
REQ-027 Mode 1: counter {b,a} starting at 0, incrementing by 1 per transfer; final transfer a=b=all-ones.
REQ-028 Mode 2: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 0x80200003), right-shift; seed 0 replaced by 1; first transfer uses the state after one step; a=state[WIDTH-1:0], b=state[2*WIDTH-1:WIDTH] (upper bits masked for WIDTH=16); one step per transfer.
REQ-029 Mode 3, or mode 0 with tbl_len=0: start moves directly to DONE next cycle, txn_count=0, out_valid never asserted.
REQ-030 start while in RUN is ignored.
REQ-031 Table writes apply in IDLE and DONE; writes in RUN are ignored; writing an entry during the start cycle takes effect for that run.
REQ-032 out_ready while out_valid=0 has no effect.

Reset
REQ-033 rst=1 forces IDLE next edge: out_valid=0, busy=0, done=0, a=0, b=0, txn_count=0, LFSR state=1, regardless of current state.
REQ-034 Reset does not clear directed-table contents; start coincident with rst is ignored.

Verification
REQ-035 WIDTH=4, table {a=10,b=5},{a=6,b=4}, tbl_len=2, mode 0, out_ready=1 -> transfers (10,5) then (6,4) on consecutive cycles, done=1 the cycle after, txn_count=2.
REQ-036 Same run with out_ready=0 for 3 cycles after RUN entry -> (10,5) held stable 3 cycles, then sequence as REQ-035, txn_count=2.
REQ-037 WIDTH=2, mode 1, out_ready=1 -> 16 transfers {b,a}=0..15 in order, done after 16th, txn_count=16.
REQ-038 Mode 2, seed=0, NUM_RAND=16 -> identical to seed=1; 16 transfers matching reference LFSR model; rerun with same seed repeats sequence.
REQ-039 Mode 3 and mode 0 with tbl_len=0 -> done=1 one cycle after start, out_valid never high, txn_count=0.
REQ-040 rst asserted mid-run after 5 transfers (mode 1) -> IDLE, all outputs zero next cycle; new start restarts at {b,a}=0.
